// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op and FSM
// encodings, GPR bus width, and small arithmetic helpers.
package muldiv_ctrl_pkg;

  localparam int unsigned GPR_W = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Two's-complement negate when en is set.
  function automatic logic [GPR_W-1:0] neg_if(input logic [GPR_W-1:0] v, input logic en);
    return en ? (~v + GPR_W'(1)) : v;
  endfunction

  // Full-width product; operands sign-extended when sgn is set, result kept modulo 2^64.
  function automatic logic [2*GPR_W-1:0] mul_wide(input logic [GPR_W-1:0] a,
                                                  input logic [GPR_W-1:0] b,
                                                  input logic             sgn);
    logic [2*GPR_W-1:0] ea;
    logic [2*GPR_W-1:0] eb;
    ea = {{GPR_W{sgn & a[GPR_W-1]}}, a};
    eb = {{GPR_W{sgn & b[GPR_W-1]}}, b};
    return ea * eb;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle,
// GPR_W iterations; done_o fires combinationally during the final iteration.
module div_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [GPR_W-1:0] dividend_i,
  input  logic [GPR_W-1:0] divisor_i,
  output logic             done_o,
  output logic [GPR_W-1:0] quot_o,
  output logic [GPR_W-1:0] rem_o
);

  localparam int unsigned CNT_W = $clog2(GPR_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GPR_W - 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GPR_W-1:0] quot_q;
  logic [GPR_W-1:0] rem_q;
  logic [GPR_W-1:0] dvs_q;

  logic [GPR_W:0]   trial_s;
  logic [GPR_W-1:0] quot_nx_s;
  logic [GPR_W-1:0] rem_nx_s;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  assign trial_s = {rem_q, quot_q[GPR_W-1]} - {1'b0, dvs_q};

  always_comb begin
    quot_nx_s = {quot_q[GPR_W-2:0], 1'b0};
    rem_nx_s  = {rem_q[GPR_W-2:0], quot_q[GPR_W-1]};
    if (!trial_s[GPR_W]) begin
      quot_nx_s = {quot_q[GPR_W-2:0], 1'b1};
      rem_nx_s  = trial_s[GPR_W-1:0];
    end else begin
      quot_nx_s = {quot_q[GPR_W-2:0], 1'b0};
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_LAST);
  assign quot_o = quot_nx_s;
  assign rem_o  = rem_nx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
      quot_q <= {GPR_W{1'b0}};
      rem_q  <= {GPR_W{1'b0}};
      dvs_q  <= {GPR_W{1'b0}};
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= {CNT_W{1'b0}};
      quot_q <= dividend_i;
      rem_q  <= {GPR_W{1'b0}};
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      quot_q <= quot_nx_s;
      rem_q  <= rem_nx_s;
      cnt_q  <= cnt_q + CNT_W'(1);
      busy_q <= (cnt_q != CNT_LAST);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide controller driving the HI/LO write port.
// Define MULDIV_ACCUM_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [GPR_W-1:0] src_a_i,
  input  logic [GPR_W-1:0] src_b_i,
  input  logic [GPR_W-1:0] hi_i,
  input  logic [GPR_W-1:0] lo_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             hi_we_o,
  output logic             lo_we_o,
  output logic [GPR_W-1:0] hi_wdata_o,
  output logic [GPR_W-1:0] lo_wdata_o
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 32'd1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*GPR_W-1:0] wdata_q, wdata_d;
  logic [GPR_W-1:0]   a_q, b_q;
  logic               sgn_q, q_neg_q, r_neg_q;

  logic               in_idle_s, accept_s, is_div_s, div_zero_s, div_start_s;
  logic               op_sgn_s;
  logic [GPR_W-1:0]   mul_a_s, mul_b_s;
  logic               mul_sgn_s;
  logic [2*GPR_W-1:0] prod_s, mul_res_s;
  logic [GPR_W-1:0]   div_a_mag_s, div_b_mag_s;
  logic               div_done_s;
  logic [GPR_W-1:0]   div_quot_s, div_rem_s, quot_fix_s, rem_fix_s;

  assign in_idle_s   = (state_q == ST_IDLE);
  assign accept_s    = in_idle_s && start_i && !flush_i;
  assign is_div_s    = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign div_zero_s  = (src_b_i == {GPR_W{1'b0}});
  assign div_start_s = accept_s && is_div_s && !div_zero_s;
  assign op_sgn_s    = ~op_i[0];

  // Live operands feed the multiplier in IDLE so MUL_LAT=1 can finish straight from accept.
  assign mul_a_s   = in_idle_s ? src_a_i : a_q;
  assign mul_b_s   = in_idle_s ? src_b_i : b_q;
  assign mul_sgn_s = in_idle_s ? op_sgn_s : sgn_q;
  assign prod_s    = mul_wide(mul_a_s, mul_b_s, mul_sgn_s);

`ifdef MULDIV_ACCUM_EN
  logic [2*GPR_W-1:0] acc_q, acc_base_s;
  logic               acc_en_q, acc_sub_q, acc_en_s, acc_sub_s;

  assign acc_base_s = in_idle_s ? {hi_i, lo_i} : acc_q;
  assign acc_en_s   = in_idle_s ? op_i[2] : acc_en_q;
  assign acc_sub_s  = in_idle_s ? op_i[1] : acc_sub_q;
  assign mul_res_s  = !acc_en_s ? prod_s :
                      (acc_sub_s ? (acc_base_s - prod_s) : (acc_base_s + prod_s));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= {(2*GPR_W){1'b0}};
      acc_en_q  <= 1'b0;
      acc_sub_q <= 1'b0;
    end else if (accept_s) begin
      acc_q     <= {hi_i, lo_i};
      acc_en_q  <= op_i[2];
      acc_sub_q <= op_i[1];
    end
  end
`else
  logic unused_acc_s;
  assign unused_acc_s = ^{hi_i, lo_i};
  assign mul_res_s    = prod_s;
`endif

  assign div_a_mag_s = neg_if(src_a_i, op_sgn_s & src_a_i[GPR_W-1]);
  assign div_b_mag_s = neg_if(src_b_i, op_sgn_s & src_b_i[GPR_W-1]);

  div_iter u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start_s),
    .abort_i    (flush_i),
    .dividend_i (div_a_mag_s),
    .divisor_i  (div_b_mag_s),
    .done_o     (div_done_s),
    .quot_o     (div_quot_s),
    .rem_o      (div_rem_s)
  );

  // Quotient sign follows the operand sign mismatch, remainder follows the dividend.
  assign quot_fix_s = neg_if(div_quot_s, q_neg_q);
  assign rem_fix_s  = neg_if(div_rem_s, r_neg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= {GPR_W{1'b0}};
      b_q     <= {GPR_W{1'b0}};
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (accept_s) begin
      a_q     <= src_a_i;
      b_q     <= src_b_i;
      sgn_q   <= op_sgn_s;
      q_neg_q <= op_sgn_s & (src_a_i[GPR_W-1] ^ src_b_i[GPR_W-1]);
      r_neg_q <= op_sgn_s & src_a_i[GPR_W-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!accept_s) begin
            state_d = ST_IDLE;
          end else if (is_div_s && div_zero_s) begin
            state_d = ST_DONE;
            wdata_d = {src_a_i, {GPR_W{1'b1}}};
          end else if (is_div_s) begin
            state_d = ST_DIV;
          end else if (MUL_LAT == 32'd1) begin
            state_d = ST_DONE;
            wdata_d = mul_res_s;
          end else begin
            state_d = ST_MUL;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_MUL: begin
          if (cnt_q <= 2'd1) begin
            state_d = ST_DONE;
            cnt_d   = {CNT_W{1'b0}};
            wdata_d = mul_res_s;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        ST_DIV: begin
          if (div_done_s) begin
            state_d = ST_DONE;
            wdata_d = {rem_fix_s, quot_fix_s};
          end else begin
            state_d = ST_DIV;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      wdata_q <= {(2*GPR_W){1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  // Stall covers the accept cycle itself, so it cannot be a registered output.
  assign stall_o    = !rst && (accept_s || (state_q == ST_MUL) || (state_q == ST_DIV));
  assign hi_we_o    = !rst && !flush_i && (state_q == ST_DONE);
  assign lo_we_o    = !rst && !flush_i && (state_q == ST_DONE);
  assign hi_wdata_o = wdata_q[2*GPR_W-1:GPR_W];
  assign lo_wdata_o = wdata_q[GPR_W-1:0];

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus randomized ops
// checked against an arithmetic reference model; honours MULDIV_ACCUM_EN.
module tb_muldiv_ctrl;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i, src_b_i, hi_i, lo_i;
  logic        flush_i;
  logic        stall_o, hi_we_o, lo_we_o;
  logic [31:0] hi_wdata_o, lo_wdata_o;

  int compared;
  int mismatched;

  muldiv_ctrl #(.MUL_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .src_a_i    (src_a_i),
    .src_b_i    (src_b_i),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .hi_we_o    (hi_we_o),
    .lo_we_o    (lo_we_o),
    .hi_wdata_o (hi_wdata_o),
    .lo_wdata_o (lo_wdata_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference result {HI, LO} from the instruction semantics.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    int ia, ib, iq, ir;
    longint sa, sb;
    longint unsigned ua, ub, p, acc;
    ia = a;
    ib = b;
    if (op == 3'd2 || op == 3'd3) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == 3'd3) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      iq = ia / ib;
      ir = ia % ib;
      return {ir, iq};
    end
    sa = longint'(ia);
    sb = longint'(ib);
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 3'd0 || op == 3'd4 || op == 3'd6) p = sa * sb;
    else p = ua * ub;
    acc = {hi, lo};
`ifdef MULDIV_ACCUM_EN
    if (op == 3'd4 || op == 3'd5) p = acc + p;
    else if (op == 3'd6 || op == 3'd7) p = acc - p;
`endif
    return p;
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] b);
    if (op == 3'd2 || op == 3'd3) return (b == 32'd0) ? 1 : 33;
    return LAT;
  endfunction

  // One operation from accept to the idle cycle after the write (or to a flush).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input logic [63:0] exp, input int poke_cyc, input int flush_cyc);
    int lat;
    lat = exp_latency(op, b);
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b; hi_i = hi; lo_i = lo; flush_i = 1'b0;
    @(negedge clk);
    chk({tag, "/accept"}, 64'({stall_o, hi_we_o, lo_we_o}), 64'(3'b100));
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      start_i = (c == poke_cyc);
      op_i = 3'($urandom);
      src_a_i = $urandom; src_b_i = $urandom; hi_i = $urandom; lo_i = $urandom;
      flush_i = (c == flush_cyc);
      @(negedge clk);
      if (c == flush_cyc) begin
        chk({tag, "/flush_we"}, 64'({hi_we_o, lo_we_o}), 64'(2'b00));
        break;
      end else if (c < lat) begin
        chk({tag, "/busy"}, 64'({stall_o, hi_we_o, lo_we_o}), 64'(3'b100));
      end else begin
        chk({tag, "/done_ctl"}, 64'({stall_o, hi_we_o, lo_we_o}), 64'(3'b011));
        chk({tag, "/data"}, {hi_wdata_o, lo_wdata_o}, exp);
      end
    end
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    if (flush_cyc == 0) begin
      @(negedge clk);
      chk({tag, "/idle_ctl"}, 64'({stall_o, hi_we_o, lo_we_o}), 64'(3'b000));
      chk({tag, "/hold"}, {hi_wdata_o, lo_wdata_o}, exp);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp;
    compared = 0;
    mismatched = 0;

    // Reset with a start pending: reset wins.
    rst = 1'b1; start_i = 1'b1; op_i = 3'd0; src_a_i = 32'd3; src_b_i = 32'd4;
    hi_i = 32'd0; lo_i = 32'd0; flush_i = 1'b0;
    @(negedge clk);
    chk("reset_ctl", 64'({stall_o, hi_we_o, lo_we_o}), 64'(3'b000));
    chk("reset_data", {hi_wdata_o, lo_wdata_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("post_reset", 64'({stall_o, hi_we_o, lo_we_o, hi_wdata_o, lo_wdata_o}), 64'd0);
    @(posedge clk); #1;

    run_op("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 0, 0);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, {32'd0, 32'h8000_0000}, 0, 0);
    run_op("divu_5_0", 3'd3, 32'd5, 32'd0, 32'd0, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0, 0);
    run_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd0, {32'd3, 32'h2492_4924}, 0, 0);
`ifdef MULDIV_ACCUM_EN
    exp = {32'd1, 32'd0};
`else
    exp = {32'd0, 32'd1};
`endif
    run_op("madd_carry", 3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, exp, 0, 0);
`ifdef MULDIV_ACCUM_EN
    exp = 64'hFFFF_FFFF_FFFF_FFFA;
`else
    exp = 64'd6;
`endif
    run_op("msubu_wrap", 3'd7, 32'd2, 32'd3, 32'd0, 32'd0, exp, 0, 0);

    // Flush in iteration 10, then a fresh start right away.
    run_op("divu_flush", 3'd3, 32'd1000, 32'd3, 32'd0, 32'd0, 64'd0, 0, 10);
    run_op("after_flush", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, {32'd1, 32'd0}, 0, 0);
    run_op("flush_done", 3'd1, 32'd9, 32'd9, 32'd0, 32'd0, 64'd81, 0, LAT);

    // Reset in MUL abandons the operation and clears the write data.
    start_i = 1'b1; op_i = 3'd0; src_a_i = 32'd7; src_b_i = 32'd6;
    @(negedge clk);
    chk("rst_mul_accept", 64'(stall_o), 64'd1);
    @(posedge clk); #1;
    start_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mul_ctl", 64'({stall_o, hi_we_o, lo_we_o}), 64'(3'b000));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mul_after", 64'({stall_o, hi_we_o, lo_we_o, hi_wdata_o, lo_wdata_o}), 64'd0);
      @(posedge clk); #1;
    end
    run_op("div_poke", 3'd2, 32'd100, 32'hFFFF_FFFD, 32'd0, 32'd0, {32'd1, 32'hFFFF_FFDF}, 5, 0);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom; hi = $urandom; lo = $urandom;
      case (i % 5)
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: a = $urandom_range(0, 50);
      endcase
      run_op("random", op, a, b, hi, lo, model(op, a, b, hi, lo), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
